// File: rtl/game_countdown_timer.sv
// Loadable, pausable BCD seconds countdown for a game round.
// Flags TimeUp once and holds Expired when the count reaches 00.
module game_countdown_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int START_SECONDS   = 60
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic [3:0] LoadTens,
    input  logic [3:0] LoadOnes,
    output logic [3:0] TensValue,
    output logic [3:0] OnesValue,
    output logic       Running,
    output logic       Expired,
    output logic       TimeUp
);

    localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(CLOCK_FREQUENCY - 1);
    localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
    localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state, state_next;
    logic [3:0]    tens, ones, tens_next, ones_next;
    logic [PW-1:0] presc, presc_next;
    logic          time_up, time_up_next;
    logic [3:0]    load_tens, load_ones;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign load_tens = clamp_bcd(LoadTens);
    assign load_ones = clamp_bcd(LoadOnes);

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            tens    <= START_TENS;
            ones    <= START_ONES;
            presc   <= RELOAD;
            time_up <= 1'b0;
        end else begin
            state   <= state_next;
            tens    <= tens_next;
            ones    <= ones_next;
            presc   <= presc_next;
            time_up <= time_up_next;
        end
    end

    always_comb begin
        state_next   = state;
        tens_next    = tens;
        ones_next    = ones;
        presc_next   = presc;
        time_up_next = 1'b0;
        if (Start) begin
            tens_next  = load_tens;
            ones_next  = load_ones;
            presc_next = RELOAD;
            if (load_tens == 4'd0 && load_ones == 4'd0) begin
                state_next   = EXPIRED;
                time_up_next = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else if (state == RUN || state == PAUSE) begin
            if (Pause) begin
                state_next = PAUSE;
            end else begin
                state_next = RUN;
                if (presc != '0) begin
                    presc_next = presc - 1'b1;
                end else begin
                    presc_next = RELOAD;
                    // One second elapsed: BCD borrow from tens when ones is 0
                    if (ones != 4'd0) begin
                        ones_next = ones - 4'd1;
                    end else if (tens != 4'd0) begin
                        ones_next = 4'd9;
                        tens_next = tens - 4'd1;
                    end
                    if (tens_next == 4'd0 && ones_next == 4'd0) begin
                        state_next   = EXPIRED;
                        time_up_next = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        TensValue = tens;
        OnesValue = ones;
        Running   = (state == RUN);
        Expired   = (state == EXPIRED);
        TimeUp    = time_up;
    end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: seconds-remaining model plus
// directed scenarios with hand-computed digit expectations.
module tb_game_countdown_timer;

    localparam int F = 4;
    localparam int S = 60;

    logic       ClockIn = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Pause = 1'b0;
    logic [3:0] LoadTens = 4'd0;
    logic [3:0] LoadOnes = 4'd0;
    logic [3:0] TensValue, OnesValue;
    logic       Running, Expired, TimeUp;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    game_countdown_timer #(
        .CLOCK_FREQUENCY(F),
        .START_SECONDS(S)
    ) dut (
        .ClockIn(ClockIn),
        .Reset(Reset),
        .Start(Start),
        .Pause(Pause),
        .LoadTens(LoadTens),
        .LoadOnes(LoadOnes),
        .TensValue(TensValue),
        .OnesValue(OnesValue),
        .Running(Running),
        .Expired(Expired),
        .TimeUp(TimeUp)
    );

    always #5 ClockIn = ~ClockIn;

    // Model: seconds left as an integer, active cycles since load
    int m_secs = S;
    int m_cnt = 0;
    int m_mode = 0;  // 0 idle, 1 run, 2 pause, 3 expired
    bit m_tu = 1'b0;

    function automatic int clampd(input logic [3:0] d);
        return (d > 9) ? 9 : int'(d);
    endfunction

    always @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            m_secs = S; m_cnt = 0; m_mode = 0; m_tu = 1'b0;
        end else begin
            m_tu = 1'b0;
            if (Start) begin
                m_secs = clampd(LoadTens) * 10 + clampd(LoadOnes);
                m_cnt = 0;
                if (m_secs == 0) begin
                    m_mode = 3; m_tu = 1'b1;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 1 || m_mode == 2) begin
                if (Pause) begin
                    m_mode = 2;
                end else begin
                    m_mode = 1;
                    m_cnt++;
                    if (m_cnt % F == 0) begin
                        m_secs--;
                        if (m_secs == 0) begin
                            m_mode = 3; m_tu = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge ClockIn) begin
        if (chk_en) begin
            chk("m_tens", int'(TensValue), m_secs / 10);
            chk("m_ones", int'(OnesValue), m_secs % 10);
            chk("m_running", int'(Running), int'(m_mode == 1));
            chk("m_expired", int'(Expired), int'(m_mode == 3));
            chk("m_timeup", int'(TimeUp), int'(m_tu));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ClockIn);
        #1;
    endtask

    task automatic digits(input string name, input int t, input int o);
        chk({name, "_tens"}, int'(TensValue), t);
        chk({name, "_ones"}, int'(OnesValue), o);
    endtask

    task automatic go(input logic [3:0] t, input logic [3:0] o);
        LoadTens = t; LoadOnes = o; Start = 1'b1;
        cyc(1);
        Start = 1'b0;
    endtask

    initial begin
        // 1: reset and idle
        Reset = 1'b1;
        #1 chk_en = 1'b1;
        cyc(2);
        Reset = 1'b0;
        cyc(20);
        digits("idle", 6, 0);
        chk("idle_run", int'(Running), 0);

        // 2: full countdown from 12
        go(4'd1, 4'd2);
        digits("s12", 1, 2);
        chk("s12_run", int'(Running), 1);
        cyc(3);
        digits("s12_hold", 1, 2);
        cyc(1);
        digits("s11", 1, 1);
        cyc(8);
        digits("s09", 0, 9);
        cyc(36);
        digits("s00", 0, 0);
        chk("s00_tu", int'(TimeUp), 1);
        chk("s00_exp", int'(Expired), 1);
        cyc(1);
        chk("s00_tu_off", int'(TimeUp), 0);
        chk("s00_run", int'(Running), 0);

        // 3: pause preserves sub-second progress
        go(4'd0, 4'd5);
        cyc(4);
        digits("p04", 0, 4);
        cyc(1);
        Pause = 1'b1;
        cyc(10);
        digits("p_frz", 0, 4);
        chk("p_run", int'(Running), 0);
        Pause = 1'b0;
        cyc(2);
        digits("p_rel1", 0, 4);
        cyc(1);
        digits("p_rel2", 0, 3);

        // 4: clamp, restart, Start beats Pause
        go(4'hF, 4'hC);
        digits("c99", 9, 9);
        cyc(5);
        go(4'd0, 4'd3);
        digits("r03", 0, 3);
        cyc(3);
        digits("r03b", 0, 3);
        cyc(1);
        digits("r02", 0, 2);
        Pause = 1'b1;
        go(4'd0, 4'd3);
        chk("sp_run", int'(Running), 1);
        digits("sp03", 0, 3);
        cyc(1);
        chk("sp_pause", int'(Running), 0);
        Pause = 1'b0;

        // 5: load 00 from idle
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        cyc(1);
        go(4'd0, 4'd0);
        chk("z_exp", int'(Expired), 1);
        chk("z_tu", int'(TimeUp), 1);
        chk("z_run", int'(Running), 0);
        cyc(3);
        chk("z_tu_off", int'(TimeUp), 0);

        // 6: async reset mid-count
        go(4'd0, 4'd9);
        cyc(8);
        digits("a07", 0, 7);
        #2 Reset = 1'b1;
        #1;
        digits("a_rst", 6, 0);
        chk("a_rst_run", int'(Running), 0);
        chk("a_rst_tu", int'(TimeUp), 0);
        cyc(2);
        Reset = 1'b0;
        cyc(1);
        go(4'd0, 4'd2);
        cyc(4);
        digits("a01", 0, 1);
        cyc(4);
        chk("a_exp", int'(Expired), 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
